ram_arbiter: RTL

//  Shares the 64-byte single-port synchronous RAM between two requesters (port 0, port 1).

---
 rtl/ram_arb_pkg.sv | 27 ++
 rtl/ram_arbiter_if.sv | 31 +++
 rtl/ram_arbiter_rr_arb2.sv | 42 ++++
 rtl/ram_arbiter.sv | 83 ++++++++
 4 files changed

// File: rtl/ram_arb_pkg.sv
// Shared types and sizes for the two-port RAM arbiter.
// Command struct mirrors the RAM's own rw/addr/data inputs.
package ram_arb_pkg;

    localparam int ADDR_W    = 6;
    localparam int DATA_W    = 8;
    localparam int NUM_PORTS = 2;

    typedef logic port_id_t;

    typedef struct packed {
        logic              rw;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } ram_cmd_t;

    function automatic ram_cmd_t mk_cmd(input logic              rw,
                                        input logic [ADDR_W-1:0] addr,
                                        input logic [DATA_W-1:0] wdata);
        ram_cmd_t c;
        c.rw    = rw;
        c.addr  = addr;
        c.wdata = wdata;
        return c;
    endfunction

endpackage

// File: rtl/ram_arbiter_if.sv
// Requester-side bundle: two command ports in, grants and read responses out.
// master = the bus masters, slave = the arbiter.
interface ram_arbiter_if;
    import ram_arb_pkg::*;

    logic              req0;
    logic              req1;
    logic              rw0;
    logic              rw1;
    logic [ADDR_W-1:0] addr0;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] wdata0;
    logic [DATA_W-1:0] wdata1;
    logic              gnt0;
    logic              gnt1;
    logic              rvalid0;
    logic              rvalid1;
    logic [DATA_W-1:0] rdata0;
    logic [DATA_W-1:0] rdata1;

    modport master (
        output req0, req1, rw0, rw1, addr0, addr1, wdata0, wdata1,
        input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1
    );

    modport slave (
        input  req0, req1, rw0, rw1, addr0, addr1, wdata0, wdata1,
        output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1
    );

endinterface

// File: rtl/ram_arbiter_rr_arb2.sv
// Two-way grant logic, combinational grant; round-robin via last_gnt register,
// or fixed port-0 priority when RAM_ARB_FIXED_PRIO_EN is defined.
module rr_arb2
    import ram_arb_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic i_req0,
    input  logic i_req1,
    output logic o_gnt0,
    output logic o_gnt1
);

`ifdef RAM_ARB_FIXED_PRIO_EN

    logic w_unused_clk;
    assign w_unused_clk = clk;

    assign o_gnt0 = ~rst & i_req0;
    assign o_gnt1 = ~rst & i_req1 & ~i_req0;

`else

    port_id_t r_last_gnt;
    logic     w_pick1;

    // Port 1 wins when alone, or on a tie when port 0 had the last grant.
    assign w_pick1 = i_req1 & (~i_req0 | (r_last_gnt == 1'b0));
    assign o_gnt1  = ~rst & w_pick1;
    assign o_gnt0  = ~rst & i_req0 & ~w_pick1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_gnt <= 1'b1;
        end else if (o_gnt0 | o_gnt1) begin
            r_last_gnt <= o_gnt1;
        end
    end

`endif

endmodule

// File: rtl/ram_arbiter.sv
// Shares one single-port sync RAM between two requesters: grant, issue (S1), response (S2).
// Read latency gnt->rvalid is 2 cycles; RAM_ARB_FIXED_PRIO_EN selects fixed priority arbitration.
module ram_arbiter
    import ram_arb_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    ram_arbiter_if.slave      bus,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_data,
    output logic              ram_rw,
    input  logic [DATA_W-1:0] ram_out
);

    ram_cmd_t          w_cmd0;
    ram_cmd_t          w_cmd1;
    ram_cmd_t          w_cmd;
    logic              w_gnt0;
    logic              w_gnt1;
    logic              w_any_gnt;

    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_data;
    logic              r_rw;
    logic              r_v1;
    port_id_t          r_id1;
    logic              r_v2;
    port_id_t          r_id2;

    rr_arb2 u_arb (
        .clk    (clk),
        .rst    (rst),
        .i_req0 (bus.req0),
        .i_req1 (bus.req1),
        .o_gnt0 (w_gnt0),
        .o_gnt1 (w_gnt1)
    );

    assign w_cmd0    = mk_cmd(bus.rw0, bus.addr0, bus.wdata0);
    assign w_cmd1    = mk_cmd(bus.rw1, bus.addr1, bus.wdata1);
    assign w_cmd     = w_gnt1 ? w_cmd1 : w_cmd0;
    assign w_any_gnt = w_gnt0 | w_gnt1;

    assign bus.gnt0  = w_gnt0;
    assign bus.gnt1  = w_gnt1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr <= '0;
            r_data <= '0;
            r_rw   <= 1'b0;
            r_v1   <= 1'b0;
            r_id1  <= 1'b0;
            r_v2   <= 1'b0;
            r_id2  <= 1'b0;
        end else begin
            if (w_any_gnt) begin
                r_addr <= w_cmd.addr;
                r_data <= w_cmd.wdata;
                r_rw   <= w_cmd.rw;
                r_v1   <= 1'b1;
                r_id1  <= w_gnt1;
            end else begin
                // Idle slot issues a harmless read at the held address.
                r_rw   <= 1'b0;
                r_v1   <= 1'b0;
            end
            r_v2  <= r_v1 & ~r_rw;
            r_id2 <= r_id1;
        end
    end

    // Masking with rst keeps a write sitting in S1 from landing on the reset edge.
    assign ram_addr    = r_addr;
    assign ram_data    = r_data;
    assign ram_rw      = r_rw & ~rst;

    assign bus.rvalid0 = r_v2 & ~rst & (r_id2 == 1'b0);
    assign bus.rvalid1 = r_v2 & ~rst & (r_id2 == 1'b1);
    assign bus.rdata0  = ram_out;
    assign bus.rdata1  = ram_out;

endmodule
